// File: rtl/if_id_pkg.sv
// Shared IF/ID bundle definitions: field widths, bit offsets and the NOP bundle.
package if_id_pkg;

    localparam int unsigned PC_W   = 32;
    localparam int unsigned INST_W = 32;
    localparam int unsigned EXC_W  = 32;
    localparam int unsigned ASID_W = 8;

    localparam int unsigned IF_ID_PAYLOAD_W = PC_W + INST_W + EXC_W + ASID_W + 3;

    // LSB-first layout: tlb_valid, tlb_miss, asid, exc, delay_slot, inst, pc4
    localparam int unsigned TLB_VALID_LSB = 0;
    localparam int unsigned TLB_MISS_LSB  = 1;
    localparam int unsigned ASID_LSB      = 2;
    localparam int unsigned EXC_LSB       = ASID_LSB + ASID_W;
    localparam int unsigned DS_LSB        = EXC_LSB + EXC_W;
    localparam int unsigned INST_LSB      = DS_LSB + 1;
    localparam int unsigned PC4_LSB       = INST_LSB + INST_W;

    typedef struct packed {
        logic [PC_W-1:0]   pc4;
        logic [INST_W-1:0] inst;
        logic              delay_slot;
        logic [EXC_W-1:0]  exc;
        logic [ASID_W-1:0] asid;
        logic              tlb_miss;
        logic              tlb_valid;
    } if_id_bundle_t;

    localparam logic [IF_ID_PAYLOAD_W-1:0] IF_ID_NOP = '0;

    function automatic logic [IF_ID_PAYLOAD_W-1:0] if_id_pack(input if_id_bundle_t b);
        return IF_ID_PAYLOAD_W'(b);
    endfunction

endpackage

// File: rtl/if_id_queue_mem.sv
// DEPTH x PAYLOAD_W register array with one write port and an asynchronous read port.
module if_id_queue_mem #(
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned PAYLOAD_W = 107,
    parameter int unsigned ADDR_W    = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [ADDR_W-1:0]    waddr,
    input  logic [PAYLOAD_W-1:0] wdata,
    input  logic [ADDR_W-1:0]    raddr,
    output logic [PAYLOAD_W-1:0] rdata
);

    logic [PAYLOAD_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/if_id_queue.sv
// IF/ID decoupling FIFO with valid/ready handshakes and single-cycle flush.
// Optional macro IF_ID_QUEUE_BYPASS_EN enables zero-latency fall-through when empty.
module if_id_queue
    import if_id_pkg::*;
#(
    parameter int unsigned PAYLOAD_W = IF_ID_PAYLOAD_W,
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned PTR_W     = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 enq_valid,
    output logic                 enq_ready,
    input  logic [PAYLOAD_W-1:0] enq_data,
    output logic                 deq_valid,
    input  logic                 deq_ready,
    output logic [PAYLOAD_W-1:0] deq_data,
    output logic [PTR_W:0]       count
);

    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(DEPTH);

    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [PAYLOAD_W-1:0] rdata;
    logic                 empty;
    logic                 enq_fire;
    logic                 deq_fire;
    logic                 do_write;
    logic                 do_read;

    assign empty     = (count == '0);
    assign enq_ready = (count != FULL_COUNT) && !flush;
    assign enq_fire  = enq_valid && enq_ready;
    assign deq_fire  = deq_valid && deq_ready;

`ifdef IF_ID_QUEUE_BYPASS_EN
    logic bypass_take;

    // An empty queue hands the incoming bundle straight to ID; storage is untouched.
    assign deq_valid   = !empty || (enq_valid && !flush);
    assign deq_data    = empty ? enq_data : rdata;
    assign bypass_take = empty && enq_valid && deq_ready && !flush;
    assign do_write    = enq_fire && !bypass_take;
    assign do_read     = deq_fire && !bypass_take;
`else
    assign deq_valid = !empty;
    assign deq_data  = empty ? '0 : rdata;
    assign do_write  = enq_fire;
    assign do_read   = deq_fire;
`endif

    if_id_queue_mem #(
        .DEPTH    (DEPTH),
        .PAYLOAD_W(PAYLOAD_W),
        .ADDR_W   (PTR_W)
    ) u_mem (
        .clk  (clk),
        .we   (do_write),
        .waddr(wr_ptr),
        .wdata(enq_data),
        .raddr(rd_ptr),
        .rdata(rdata)
    );

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_write) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_read) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_write, do_read})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_if_id_queue.sv
// Directed self-checking bench for if_id_queue at DEPTH=4.
module tb_if_id_queue;
  import if_id_pkg::*;

  localparam int unsigned W = IF_ID_PAYLOAD_W;

  logic         clk = 1'b0;
  logic         rst;
  logic         flush;
  logic         enq_valid;
  logic         enq_ready;
  logic [W-1:0] enq_data;
  logic         deq_valid;
  logic         deq_ready;
  logic [W-1:0] deq_data;
  logic [2:0]   count;

  int unsigned errors = 0;
  int unsigned checks = 0;

  if_id_queue #(.PAYLOAD_W(W), .DEPTH(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .enq_valid(enq_valid),
    .enq_ready(enq_ready),
    .enq_data (enq_data),
    .deq_valid(deq_valid),
    .deq_ready(deq_ready),
    .deq_data (deq_data),
    .count    (count)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] mk(input logic [31:0] inst);
    logic [W-1:0] p;
    p = '0;
    p[INST_LSB +: INST_W] = inst;
    p[PC4_LSB +: PC_W]    = 32'h0040_0000 + inst;
    p[ASID_LSB +: ASID_W] = inst[7:0] ^ 8'h5A;
    return p;
  endfunction

  task automatic check(input string tag, input logic ok, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    if (ok !== 1'b1) begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; flush = 1'b0; enq_valid = 1'b0; deq_ready = 1'b0; enq_data = '0;
    tick(); tick();
    rst = 1'b0;
    #1;
    check("rst_count", count === 3'd0, W'(count), W'(3'd0));
    check("rst_deq_valid", deq_valid === 1'b0, W'(deq_valid), W'(1'b0));
    check("rst_deq_data", deq_data === {W{1'b0}}, deq_data, {W{1'b0}});
    check("rst_enq_ready", enq_ready === 1'b1, W'(enq_ready), W'(1'b1));

    for (int unsigned i = 0; i < 4; i++) begin
      enq_valid = 1'b1; enq_data = mk(32'hA0 + i);
      #1;
      check("fill_enq_ready", enq_ready === 1'b1, W'(enq_ready), W'(1'b1));
      tick();
    end
    enq_data = mk(32'hA4);
    #1;
    check("full_count", count === 3'd4, W'(count), W'(3'd4));
    check("full_enq_ready", enq_ready === 1'b0, W'(enq_ready), W'(1'b0));
    check("full_head", deq_data === mk(32'hA0), deq_data, mk(32'hA0));
    tick();
    check("full_reject_count", count === 3'd4, W'(count), W'(3'd4));

    deq_ready = 1'b1;
    #1;
    check("full_deq_enq_ready", enq_ready === 1'b0, W'(enq_ready), W'(1'b0));
    check("deq0", deq_data === mk(32'hA0), deq_data, mk(32'hA0));
    tick();
    enq_valid = 1'b0;
    #1;
    check("after_full_deq_count", count === 3'd3, W'(count), W'(3'd3));
    check("deq1", deq_data === mk(32'hA1), deq_data, mk(32'hA1));
    tick();
    deq_ready = 1'b0;
    #1;
    check("drain2_count", count === 3'd2, W'(count), W'(3'd2));

    enq_valid = 1'b1; enq_data = mk(32'hB0); tick();
    enq_data = mk(32'hB1); tick();
    enq_valid = 1'b0;
    #1;
    check("wrap_count", count === 3'd4, W'(count), W'(3'd4));
    deq_ready = 1'b1;
    check("wrap_deq_A2", deq_data === mk(32'hA2), deq_data, mk(32'hA2)); tick();
    check("wrap_deq_A3", deq_data === mk(32'hA3), deq_data, mk(32'hA3)); tick();
    check("wrap_deq_B0", deq_data === mk(32'hB0), deq_data, mk(32'hB0)); tick();
    check("wrap_deq_B1", deq_data === mk(32'hB1), deq_data, mk(32'hB1)); tick();
    deq_ready = 1'b0;
    #1;
    check("drained_count", count === 3'd0, W'(count), W'(3'd0));
    check("drained_deq_valid", deq_valid === 1'b0, W'(deq_valid), W'(1'b0));
    check("drained_deq_data", deq_data === {W{1'b0}}, deq_data, {W{1'b0}});

    enq_valid = 1'b1; enq_data = mk(32'hE0); tick();
    enq_data = mk(32'hE1); tick();
    deq_ready = 1'b1;
    for (int unsigned k = 0; k < 5; k++) begin
      enq_data = mk(32'hE2 + k);
      #1;
      check("sim_count", count === 3'd2, W'(count), W'(3'd2));
      check("sim_head", deq_data === mk(32'hE0 + k), deq_data, mk(32'hE0 + k));
      tick();
    end
    deq_ready = 1'b0;
    #1;
    check("sim_end_count", count === 3'd2, W'(count), W'(3'd2));
    check("sim_end_head", deq_data === mk(32'hE5), deq_data, mk(32'hE5));

    enq_data = mk(32'hE7); tick();
    enq_data = mk(32'hC9); flush = 1'b1; deq_ready = 1'b1;
    #1;
    check("flush_pre_count", count === 3'd3, W'(count), W'(3'd3));
    check("flush_enq_ready", enq_ready === 1'b0, W'(enq_ready), W'(1'b0));
    tick();
    flush = 1'b0; enq_valid = 1'b0; deq_ready = 1'b0;
    #1;
    check("flush_count", count === 3'd0, W'(count), W'(3'd0));
    check("flush_deq_valid", deq_valid === 1'b0, W'(deq_valid), W'(1'b0));
    enq_valid = 1'b1; enq_data = mk(32'hC0);
    tick();
    enq_valid = 1'b0;
    #1;
    check("post_flush_count", count === 3'd1, W'(count), W'(3'd1));
    check("post_flush_head", deq_data === mk(32'hC0), deq_data, mk(32'hC0));

    rst = 1'b1; flush = 1'b1; enq_valid = 1'b1; enq_data = mk(32'hF0);
    tick();
    rst = 1'b0; flush = 1'b0; enq_valid = 1'b0;
    #1;
    check("midrst_count", count === 3'd0, W'(count), W'(3'd0));
    check("midrst_deq_valid", deq_valid === 1'b0, W'(deq_valid), W'(1'b0));

    enq_valid = 1'b1; enq_data = mk(32'hD0); deq_ready = 1'b1;
    #1;
`ifdef IF_ID_QUEUE_BYPASS_EN
    check("byp_deq_valid", deq_valid === 1'b1, W'(deq_valid), W'(1'b1));
    check("byp_deq_data", deq_data === mk(32'hD0), deq_data, mk(32'hD0));
    tick();
    enq_valid = 1'b0; deq_ready = 1'b0;
    #1;
    check("byp_count", count === 3'd0, W'(count), W'(3'd0));
    check("byp_after_valid", deq_valid === 1'b0, W'(deq_valid), W'(1'b0));
`else
    check("nobyp_deq_valid", deq_valid === 1'b0, W'(deq_valid), W'(1'b0));
    check("nobyp_deq_data", deq_data === {W{1'b0}}, deq_data, {W{1'b0}});
    tick();
    enq_valid = 1'b0; deq_ready = 1'b0;
    #1;
    check("nobyp_count", count === 3'd1, W'(count), W'(3'd1));
    check("nobyp_head", deq_data === mk(32'hD0), deq_data, mk(32'hD0));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
